// File: rtl/alu_op_seq_pkg.sv
// rtl/alu_op_seq_pkg.sv - shared types and constants for the ALU op sequencer
package alu_op_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // MUL and DIV need unit_done; ADD and SUB finish in one cycle
  localparam logic [3:0] DEFAULT_MULTI_MASK = 4'b1100;

endpackage

// File: rtl/alu_op_seq_timer.sv
// rtl/alu_op_seq_timer.sv - clearable wait-cycle counter with terminal-count flag
module alu_op_seq_timer
  import alu_op_seq_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_count;

  // count cycles spent waiting; held at zero whenever the sequencer is not waiting
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU op sequencer top; ALU_OP_SEQ_PERF_CNT_EN adds perf counters
module alu_op_sequencer
  import alu_op_seq_pkg::*;
#(
  parameter int                     OP_W       = 2,
  parameter logic [2**OP_W-1:0]     MULTI_MASK = (2**OP_W)'(DEFAULT_MULTI_MASK),
  parameter int                     TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [OP_W-1:0]      op_code,
  input  logic                 abort,
  output logic [2**OP_W-1:0]   unit_start,
  input  logic [2**OP_W-1:0]   unit_done,
  output logic [2**OP_W-1:0]   select,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OP_W-1:0]      res_op,
  output logic                 timeout_err,
  output logic                 busy
`ifdef ALU_OP_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_ops,
  output logic [15:0]          perf_timeouts
`endif
);

  localparam int NUM_OPS = 2**OP_W;

  state_e              r_state, w_state_nxt;
  logic [OP_W-1:0]     r_cur_op, w_cur_op_nxt;
  logic                r_timeout_err, w_timeout_err_nxt;
  logic [NUM_OPS-1:0]  r_unit_start, w_unit_start_nxt;
  logic [NUM_OPS-1:0]  w_op_onehot;
  logic [NUM_OPS-1:0]  w_cur_onehot;
  logic                w_accept;
  logic                w_done;
  logic                w_timer_tc;
  logic                w_timer_clr;
  logic                w_res_valid;

  assign w_op_onehot  = {{(NUM_OPS-1){1'b0}}, 1'b1} << op_code;
  assign w_cur_onehot = {{(NUM_OPS-1){1'b0}}, 1'b1} << r_cur_op;

  assign op_ready = reset_n & ~abort &
                    ((r_state == IDLE) | ((r_state == HOLD) & res_ready));
  assign w_accept = op_valid & op_ready;

  // only the unit that was started can complete the current op
  assign w_done = unit_done[r_cur_op];

  // timer restarts from zero on every entry into WAIT
  assign w_timer_clr = (r_state != WAIT) | abort;

  generate
    if (TIMEOUT != 0) begin : g_timer
      alu_op_seq_timer #(
        .TIMEOUT (TIMEOUT)
      ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_timer_clr),
        .i_en    (r_state == WAIT),
        .o_tc    (w_timer_tc)
      );
    end else begin : g_no_timer
      assign w_timer_tc = 1'b0;
    end
  endgenerate

  // next-state decode: abort first, then done-before-timeout, then accept of a new op
  always_comb begin
    w_state_nxt       = r_state;
    w_cur_op_nxt      = r_cur_op;
    w_timeout_err_nxt = r_timeout_err;
    w_unit_start_nxt  = '0;
    if (abort) begin
      w_state_nxt       = IDLE;
      w_timeout_err_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        WAIT: begin
          if (w_done) begin
            w_state_nxt       = HOLD;
            w_timeout_err_nxt = 1'b0;
          end else if (w_timer_tc) begin
            w_state_nxt       = HOLD;
            w_timeout_err_nxt = 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            w_state_nxt       = IDLE;
            w_timeout_err_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
      // accept only happens from IDLE or a draining HOLD, so it overrides those moves
      if (w_accept) begin
        w_cur_op_nxt      = op_code;
        w_timeout_err_nxt = 1'b0;
        if (MULTI_MASK[op_code]) begin
          w_state_nxt      = WAIT;
          w_unit_start_nxt = w_op_onehot;
        end else begin
          w_state_nxt = HOLD;
        end
      end
    end
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cur_op      <= '0;
      r_timeout_err <= 1'b0;
      r_unit_start  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur_op      <= w_cur_op_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_unit_start  <= w_unit_start_nxt;
    end
  end

  assign w_res_valid = (r_state == HOLD);
  assign res_valid   = w_res_valid;
  assign res_op      = r_cur_op;
  assign timeout_err = r_timeout_err;
  assign unit_start  = r_unit_start;
  assign select      = (r_state == IDLE) ? '0 : w_cur_onehot;
  assign busy        = (r_state != IDLE);

`ifdef ALU_OP_SEQ_PERF_CNT_EN
  logic [31:0] r_perf_ops;
  logic [15:0] r_perf_timeouts;

  // count result transfers and those that carried a timeout; both wrap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_ops      <= '0;
      r_perf_timeouts <= '0;
    end else if (w_res_valid & res_ready) begin
      r_perf_ops <= r_perf_ops + 32'd1;
      if (r_timeout_err) begin
        r_perf_timeouts <= r_perf_timeouts + 16'd1;
      end
    end
  end

  assign perf_ops      = r_perf_ops;
  assign perf_timeouts = r_perf_timeouts;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset_n;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_code;
  logic       abort;
  logic [3:0] unit_start;
  logic [3:0] unit_done;
  logic [3:0] select;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_op;
  logic       timeout_err;
  logic       busy;
`ifdef ALU_OP_SEQ_PERF_CNT_EN
  logic [31:0] perf_ops;
  logic [15:0] perf_timeouts;
`endif

  int n_checks;
  int n_pass;

  alu_op_sequencer #(
    .OP_W       (2),
    .MULTI_MASK (4'b1100),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .abort       (abort),
    .unit_start  (unit_start),
    .unit_done   (unit_done),
    .select      (select),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_op      (res_op),
    .timeout_err (timeout_err),
    .busy        (busy)
`ifdef ALU_OP_SEQ_PERF_CNT_EN
    ,
    .perf_ops      (perf_ops),
    .perf_timeouts (perf_timeouts)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    op_valid  = 1'b1;
    op_code   = 2'd0;
    abort     = 1'b0;
    unit_done = 4'b0000;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (op_ready !== 1'b0) $display("FAIL rst_op_ready got %0b exp 0", op_ready);
      else n_pass++;
      n_checks++;
      if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %0b exp 0", res_valid);
      else n_pass++;
      n_checks++;
      if (select !== 4'b0000) $display("FAIL rst_select got %b exp 0000", select);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy);
      else n_pass++;
    end
    tick();
    reset_n  = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (op_ready !== 1'b1) $display("FAIL rst_release_op_ready got %0b exp 1", op_ready);
    else n_pass++;
    n_checks++;
    if (res_op !== 2'd0 || timeout_err !== 1'b0 || unit_start !== 4'b0000)
      $display("FAIL rst_outputs got op=%0d terr=%0b start=%b exp 0/0/0000", res_op, timeout_err, unit_start);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0)
      $display("FAIL rst_no_accept got busy=%0b valid=%0b exp 0/0", busy, res_valid);
    else n_pass++;
`ifdef ALU_OP_SEQ_PERF_CNT_EN
    n_checks++;
    if (perf_ops !== 32'd0 || perf_timeouts !== 16'd0)
      $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_ops, perf_timeouts);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [3];
    logic [3:0] sels [3];
    ops[0] = 2'd0; ops[1] = 2'd1; ops[2] = 2'd0;
    sels[0] = 4'b0001; sels[1] = 4'b0010; sels[2] = 4'b0001;
    tick();
    res_ready = 1'b1;
    op_valid  = 1'b1;
    op_code   = ops[0];
    @(negedge clk);
    n_checks++;
    if (op_ready !== 1'b1) $display("FAIL b2b_first_ready got %0b exp 1", op_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) begin
        op_valid = 1'b1;
        op_code  = ops[i+1];
      end else begin
        op_valid = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_op !== ops[i])
        $display("FAIL b2b_result[%0d] got valid=%0b op=%0d exp 1/%0d", i, res_valid, res_op, ops[i]);
      else n_pass++;
      n_checks++;
      if (select !== sels[i]) $display("FAIL b2b_select[%0d] got %b exp %b", i, select, sels[i]);
      else n_pass++;
      n_checks++;
      if (unit_start !== 4'b0000) $display("FAIL b2b_unit_start[%0d] got %b exp 0000", i, unit_start);
      else n_pass++;
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || select !== 4'b0000)
      $display("FAIL b2b_idle got valid=%0b busy=%0b sel=%b exp 0/0/0000", res_valid, busy, select);
    else n_pass++;
  endtask

  task automatic test_multi_cycle();
    op_valid  = 1'b1;
    op_code   = 2'd2;
    res_ready = 1'b1;
    tick();
    op_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 3) unit_done = 4'b1000;
      if (k == 5) unit_done = 4'b0100;
      @(negedge clk);
      n_checks++;
      if (unit_start !== ((k == 1) ? 4'b0100 : 4'b0000))
        $display("FAIL mc_unit_start[%0d] got %b exp %b", k, unit_start, (k == 1) ? 4'b0100 : 4'b0000);
      else n_pass++;
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1 || select !== 4'b0100)
        $display("FAIL mc_wait[%0d] got valid=%0b busy=%0b sel=%b exp 0/1/0100", k, res_valid, busy, select);
      else n_pass++;
      tick();
      unit_done = 4'b0000;
    end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_op !== 2'd2 || timeout_err !== 1'b0)
      $display("FAIL mc_result got valid=%0b op=%0d terr=%0b exp 1/2/0", res_valid, res_op, timeout_err);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL mc_drain got valid=%0b busy=%0b exp 0/0", res_valid, busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    op_valid  = 1'b1;
    op_code   = 2'd3;
    res_ready = 1'b0;
    tick();
    op_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0) $display("FAIL to_wait[%0d] got valid=%0b exp 0", k, res_valid);
      else n_pass++;
      tick();
    end
    op_valid = 1'b1;
    op_code  = 2'd0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_op !== 2'd3 || timeout_err !== 1'b1)
        $display("FAIL to_hold[%0d] got valid=%0b op=%0d terr=%0b exp 1/3/1", j, res_valid, res_op, timeout_err);
      else n_pass++;
      n_checks++;
      if (op_ready !== 1'b0) $display("FAIL to_hold_ready[%0d] got %0b exp 0", j, op_ready);
      else n_pass++;
      tick();
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (op_ready !== 1'b1) $display("FAIL to_release_ready got %0b exp 1", op_ready);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL to_drain got valid=%0b busy=%0b exp 0/0", res_valid, busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    op_valid  = 1'b1;
    op_code   = 2'd2;
    res_ready = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    abort     = 1'b1;
    unit_done = 4'b0100;
    op_valid  = 1'b1;
    op_code   = 2'd0;
    @(negedge clk);
    n_checks++;
    if (op_ready !== 1'b0) $display("FAIL ab_op_ready got %0b exp 0", op_ready);
    else n_pass++;
    tick();
    abort     = 1'b0;
    unit_done = 4'b0000;
    op_valid  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || select !== 4'b0000)
      $display("FAIL ab_idle got valid=%0b busy=%0b sel=%b exp 0/0/0000", res_valid, busy, select);
    else n_pass++;
    n_checks++;
    if (op_ready !== 1'b1 || timeout_err !== 1'b0)
      $display("FAIL ab_ready got ready=%0b terr=%0b exp 1/0", op_ready, timeout_err);
    else n_pass++;
    unit_done = 4'b0100;
    tick();
    unit_done = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL ab_late_done got valid=%0b busy=%0b exp 0/0", res_valid, busy);
    else n_pass++;
  endtask

`ifdef ALU_OP_SEQ_PERF_CNT_EN
  task automatic test_perf();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n   = 1'b1;
    res_ready = 1'b1;
    op_valid  = 1'b1;
    op_code   = 2'd0;
    tick();
    tick();
    tick();
    op_valid = 1'b0;
    tick();
    op_valid = 1'b1;
    op_code  = 2'd3;
    tick();
    op_valid = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    @(negedge clk);
    n_checks++;
    if (perf_ops !== 32'd4) $display("FAIL perf_ops got %0d exp 4", perf_ops);
    else n_pass++;
    n_checks++;
    if (perf_timeouts !== 16'd1) $display("FAIL perf_timeouts got %0d exp 1", perf_timeouts);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_back_to_back();
    test_multi_cycle();
    test_timeout();
    test_abort();
`ifdef ALU_OP_SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
